gray_ramp_counter: RTL and testbench

- Generates the gray-coded ramp count that the per-column gray-to-binary capture logic latches when its comparator fires.
- Counts from 0 up to a programmable terminal value and presents the count as registered gray code, so exactly one output bit toggles per increment.
- Supports single-shot and continuous (wrapping) conversion, pause and abort.
- Also presents the matching binary count for debug and for DAC ramp drive.

---
 rtl/gray_ramp_counter_pkg.sv | 11 +
 rtl/gray_ramp_counter.sv | 97 +++++++++
 tb/tb_gray_ramp_counter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gray_ramp_counter_pkg.sv
// gray_ramp_counter_pkg: shared ramp width, FSM states and binary-to-gray encoder
//   COUNT_WIDTH : ramp width, shared with the per-column gray-to-binary capture side
//   state_t     : ramp controller states
//   bin2gray    : binary to reflected gray code
package gray_ramp_counter_pkg;
   localparam int COUNT_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic [COUNT_WIDTH-1:0] bin2gray(input logic [COUNT_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/gray_ramp_counter.sv
// gray_ramp_counter: programmable gray-coded ramp counter for column ADC capture
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : begin a ramp (sampled in IDLE only)
//   abort      : cancel ramp, return to IDLE
//   en         : count enable, 0 pauses in RUN
//   cont       : continuous (wrapping) mode, latched with start
//   last_count : terminal binary count, latched with start
//   gray_out   : registered gray count
//   bin_out    : registered binary count, cycle-aligned with gray_out
//   busy       : high in RUN
//   done       : one-cycle pulse at end of a single-shot ramp
module gray_ramp_counter
   import gray_ramp_counter_pkg::*;
#(
   parameter int WIDTH = COUNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             en,
   input  logic             cont,
   input  logic [WIDTH-1:0] last_count,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             busy,
   output logic             done
);
   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic [WIDTH-1:0] r_last;
   logic             r_cont;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   // gray is encoded from the next binary value and registered alongside it,
   // so gray_out never passes through combinational logic after the flop
   assign w_bin_next  = r_bin + 1'b1;
   assign w_gray_next = bin2gray(w_bin_next);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_bin   <= '0;
         r_gray  <= '0;
         r_last  <= '0;
         r_cont  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start && !abort) begin
                  r_last  <= last_count;
                  r_cont  <= cont;
                  r_bin   <= '0;
                  r_gray  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  r_bin   <= '0;
                  r_gray  <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (en) begin
                  if (r_bin != r_last) begin
                     r_bin  <= w_bin_next;
                     r_gray <= w_gray_next;
                  end else if (r_cont) begin
                     r_bin  <= '0;
                     r_gray <= '0;
                  end else begin
                     // single-shot end: outputs keep the terminal code
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
   assign gray_out = r_gray;
   assign bin_out  = r_bin;
   assign busy     = r_busy;
   assign done     = r_done;
endmodule

// File: tb/tb_gray_ramp_counter.sv
// tb_gray_ramp_counter: directed self-checking bench for gray_ramp_counter
module tb_gray_ramp_counter;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         en = 1'b0;
   logic         cont = 1'b0;
   logic [W-1:0] last_count = '0;
   logic [W-1:0] gray_out;
   logic [W-1:0] bin_out;
   logic         busy;
   logic         done;
   int           n_checks = 0;
   int           n_errors = 0;
   gray_ramp_counter dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .en         (en),
      .cont       (cont),
      .last_count (last_count),
      .gray_out   (gray_out),
      .bin_out    (bin_out),
      .busy       (busy),
      .done       (done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   task automatic do_start(input logic [W-1:0] lc, input logic c);
      last_count = lc;
      cont       = c;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask
   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] seq5 [5] = '{8'd1, 8'd3, 8'd2, 8'd6, 8'd7};
      int           saw_wrap;
      #3;
      check("rst_gray", gray_out, 0);
      check("rst_bin", bin_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b1;
      en    = 1'b1;
      step();
      check("idle_busy", busy, 0);
      // single shot to 5
      do_start(8'd5, 1'b0);
      last_count = 8'd200;
      cont       = 1'b1;
      check("ss_busy", busy, 1);
      check("ss_gray0", gray_out, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("ss_gray", gray_out, seq5[i]);
         check("ss_done_low", done, 0);
      end
      step();
      check("ss_done", done, 1);
      check("ss_busy_fall", busy, 0);
      check("ss_gray_hold", gray_out, 7);
      check("ss_bin_hold", bin_out, 5);
      step();
      check("ss_done_1cyc", done, 0);
      check("ss_gray_hold2", gray_out, 7);
      // full continuous ramp
      do_start(8'd255, 1'b1);
      saw_wrap = 0;
      for (int i = 0; i < 600; i++) begin
         prev = gray_out;
         step();
         check("full_hamming", $countones(prev ^ gray_out), 1);
         check("full_decode", bin_out, g2b(gray_out));
         check("full_nodone", done, 0);
         if (prev == 8'd128 && gray_out == 8'd0) saw_wrap++;
      end
      check("full_wraps", saw_wrap, 2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("full_abort_busy", busy, 0);
      check("full_abort_gray", gray_out, 0);
      // pause
      do_start(8'd20, 1'b0);
      for (int i = 0; i < 3; i++) step();
      check("pause_g3", gray_out, 2);
      en = 1'b0;
      step();
      check("pause_hold1", gray_out, 2);
      step();
      check("pause_hold2", gray_out, 2);
      check("pause_bin", bin_out, 3);
      en = 1'b1;
      step();
      check("pause_g4", gray_out, 6);
      step();
      check("pause_g5", gray_out, 7);
      // abort at 10
      for (int i = 0; i < 5; i++) step();
      check("abort_bin10", bin_out, 10);
      check("abort_gray10", gray_out, 15);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_gray", gray_out, 0);
      check("abort_bin", bin_out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      step();
      check("abort_idle", busy, 0);
      do_start(8'd3, 1'b0);
      check("restart_busy", busy, 1);
      check("restart_gray", gray_out, 0);
      step();
      check("restart_g1", gray_out, 1);
      abort = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_idle", busy, 0);
      check("start_abort_bin", bin_out, 0);
      // last_count = 0
      do_start(8'd0, 1'b0);
      check("lc0_busy", busy, 1);
      check("lc0_done0", done, 0);
      start = 1'b1;
      step();
      check("lc0_done", done, 1);
      check("lc0_busy_fall", busy, 0);
      step();
      start = 1'b0;
      check("lc0_done_end", done, 0);
      check("lc0_start_ignored", busy, 0);
      // async reset at count 40
      do_start(8'd100, 1'b0);
      for (int i = 0; i < 40; i++) step();
      check("rst40_bin", bin_out, 40);
      check("rst40_gray", gray_out, 60);
      #2;
      reset = 1'b0;
      #1;
      check("arst_gray", gray_out, 0);
      check("arst_bin", bin_out, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      #1;
      reset = 1'b1;
      step();
      step();
      check("post_rst_busy", busy, 0);
      check("post_rst_bin", bin_out, 0);
      do_start(8'd2, 1'b0);
      check("post_rst_start", busy, 1);
      step();
      check("post_rst_g1", gray_out, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
